joy_serial_scanner: RTL and testbench
=====================================

// Module: joy_serial_scanner
// PURPOSE
//  Sequences the board's 74HC165 joystick shift-register chain (JOY_LOAD/JOY_CLK/JOY_DATA/JOY_SEL).
//  Periodically latches both DB9 ports twice (JOY_SEL=1, then 0) and decodes Megadrive 3-button state.
//  Sits in the board top beside the guest core; drives guest joystick inputs. Sole owner of the chain.
// PARAMETERS
//  CLK_DIV        16     clk cycles per JOY_CLK half-period; also the JOY_LOAD pulse width (>=2)
//  CHAIN_BITS     16     bits shifted per phase; port 1 = first 8 bits out, port 2 = last 8
//  SEL_SETTLE     128    clk cycles JOY_SEL held before JOY_LOAD in each phase
//  SCAN_INTERVAL  50000  idle clk cycles between scans (1 kHz at 50 MHz)
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  scan_en   in   1   1 = run periodic scans
//  JOY_CLK   out  1   shift clock to chain; rising edge shifts
//  JOY_LOAD  out  1   parallel load, active-low
//  JOY_SEL   out  1   Megadrive select line to both ports
//  JOY_DATA  in   1   serial data from chain, active-low buttons, MSB first
//  joy1      out  8   port 1 {start,a,c,b,right,left,down,up}, active-high
//  joy2      out  8   port 2, same layout
//  raw_hi    out  16  inverted chain word captured with JOY_SEL=1
//  raw_lo    out  16  inverted chain word captured with JOY_SEL=0
//  valid     out  1   one-cycle pulse when joy1/joy2/raw_* update
// BEHAVIOUR
//  One clock, one reset: reset is asynchronous and active-high; all state is clocked on clk.
//  Reset values: JOY_CLK=0, JOY_LOAD=1, JOY_SEL=1, joy1=joy2=0, raw_hi=raw_lo=0, valid=0, state=IDLE, timer=SCAN_INTERVAL-1.
//  States: IDLE -> SETTLE -> LOAD -> SHIFT -> (phase 0: SETTLE with JOY_SEL=0 | phase 1: DONE) -> IDLE.
//  IDLE: timer decrements only while scan_en=1; at 0 with scan_en=1 -> SETTLE, phase=0, JOY_SEL=1.
//  SETTLE: SEL_SETTLE cycles, JOY_SEL = ~phase. LOAD: JOY_LOAD=0 for CLK_DIV cycles, then 1.
//  SHIFT: per bit, CLK_DIV cycles JOY_CLK=0, JOY_DATA sampled on last low cycle into shreg LSB (shift left),
//   then CLK_DIV cycles JOY_CLK=1; repeat CHAIN_BITS times; JOY_CLK returns to 0 on exit.
//  Phase word stored inverted in internal capture reg; raw_*/joy* outputs update only in DONE (atomic).
//  Per-phase byte p (active-high): b0 up, b1 down, b2 left, b3 right, b4 pin6, b5 pin9, b7:6 ignored.
//  Decode: up/down/left/right/b/c from hi byte (pin6=B, pin9=C); a/start from lo byte (pin6=A, pin9=Start).
//  DONE: one cycle, valid=1, JOY_SEL=1, timer reloads SCAN_INTERVAL-1 -> IDLE.
//  Scan latency = 2*(SEL_SETTLE + CLK_DIV + 2*CLK_DIV*CHAIN_BITS) + 1 = 1313 clk at defaults.
//  scan_en dropped mid-scan: current scan completes and publishes; no new scan until scan_en=1.
//  scan_en=1 and timer=0 in same cycle as exit from DONE is impossible (timer reloaded in DONE).
//  Reset mid-scan: abort immediately to reset values; a partially shifted word is discarded.
//  Counters sized $clog2 of their max+1; no wrap occurs outside the stated reloads.
// STRUCTURE
//  Package joy_scan_pkg: state enum (IDLE,SETTLE,LOAD,SHIFT,DONE); bit index localparams (UP..PIN9);
//   Megadrive output bit positions.
//  One sub-module natural: joy_tick_gen (CLK_DIV divider producing half-period enable), reset with block.
//  Remaining FSM, shift register, decode in this module (~200 lines).
// TESTING
//  Reset: assert reset mid-run -> JOY_LOAD=1, JOY_CLK=0, JOY_SEL=1, joy1=joy2=0, valid=0 async.
//  Idle chain (JOY_DATA model all 1s), scan_en=1 -> first valid 50000+1313 clk after reset, joy1=joy2=8'h00.
//  Port1 up held both phases, pin6 low only when JOY_SEL=0 -> joy1=8'h41, raw_hi=16'h0100, raw_lo=16'h1100.
//  Port2 right + pin9 low only when JOY_SEL=0 -> joy2=8'h88, joy1=8'h00; verify exactly 16 JOY_CLK rises/phase.
//  scan_en 1->0 during SHIFT of phase 0 -> scan finishes, one valid pulse, no JOY_LOAD for >=200000 clk.
//  Reset during phase-1 SHIFT, then release -> outputs stay 0 until next full scan publishes fresh data.

Source files
------------

// File: rtl/joy_scan_pkg.sv
// joy_scan_pkg: shared state type, chain byte bit positions
// and the Megadrive 3-button decode used by the scanner.
package joy_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LOAD,
        SHIFT,
        DONE
    } scan_state_e;

    // Bit positions inside one port byte of a captured chain word.
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int PIN6  = 4;
    localparam int PIN9  = 5;

    // Bit positions of the decoded Megadrive output byte.
    localparam int MD_UP    = 0;
    localparam int MD_DOWN  = 1;
    localparam int MD_LEFT  = 2;
    localparam int MD_RIGHT = 3;
    localparam int MD_B     = 4;
    localparam int MD_C     = 5;
    localparam int MD_A     = 6;
    localparam int MD_START = 7;

    // hi = byte captured with SEL=1, lo = byte captured with SEL=0.
    function automatic logic [7:0] md_decode(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        logic [7:0] md;
        md           = '0;
        md[MD_UP]    = hi[UP];
        md[MD_DOWN]  = hi[DOWN];
        md[MD_LEFT]  = hi[LEFT];
        md[MD_RIGHT] = hi[RIGHT];
        md[MD_B]     = hi[PIN6];
        md[MD_C]     = hi[PIN9];
        md[MD_A]     = lo[PIN6];
        md[MD_START] = lo[PIN9];
        return md;
    endfunction

endpackage

// File: rtl/joy_serial_scanner_if.sv
// joy_serial_scanner_if: the four wires of the 74HC165
// joystick chain; the scanner is master, the chain is slave.
interface joy_serial_scanner_if;

    logic JOY_CLK;
    logic JOY_LOAD;
    logic JOY_SEL;
    logic JOY_DATA;

    modport master (
        output JOY_CLK,
        output JOY_LOAD,
        output JOY_SEL,
        input  JOY_DATA
    );

    modport slave (
        input  JOY_CLK,
        input  JOY_LOAD,
        input  JOY_SEL,
        output JOY_DATA
    );

endinterface

// File: rtl/joy_tick_gen.sv
// joy_tick_gen: counts CLK_DIV cycles while run is high and
// pulses tick on the last one; restarts from zero when run drops.
module joy_tick_gen
    import joy_scan_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    // Next count: hold at zero while idle, wrap after each tick.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joy_serial_scanner.sv
// joy_serial_scanner: periodically reads both DB9 ports through
// the shift-register chain in two SEL phases and decodes them.
module joy_serial_scanner
    import joy_scan_pkg::*;
#(
    parameter int CLK_DIV       = 16,
    parameter int CHAIN_BITS    = 16,
    parameter int SEL_SETTLE    = 128,
    parameter int SCAN_INTERVAL = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_en,
    joy_serial_scanner_if.master  chain,
    output logic [7:0]            joy1,
    output logic [7:0]            joy2,
    output logic [CHAIN_BITS-1:0] raw_hi,
    output logic [CHAIN_BITS-1:0] raw_lo,
    output logic                  valid
);

    localparam int TMAX = (SCAN_INTERVAL > SEL_SETTLE) ?
                          SCAN_INTERVAL : SEL_SETTLE;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
    localparam int N  = CHAIN_BITS;

    localparam logic [TW-1:0] SCAN_RELOAD   = TW'(SCAN_INTERVAL - 1);
    localparam logic [TW-1:0] SETTLE_RELOAD = TW'(SEL_SETTLE - 1);
    localparam logic [BW-1:0] LAST_BIT      = BW'(CHAIN_BITS - 1);

    scan_state_e   state_q, state_d;
    logic          phase_q, phase_d;
    logic          half_q, half_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [N-1:0]  cap_q, cap_d;
    logic [N-1:0]  raw_hi_q, raw_hi_d;
    logic [N-1:0]  raw_lo_q, raw_lo_d;
    logic [7:0]    joy1_q, joy1_d;
    logic [7:0]    joy2_q, joy2_d;
    logic          jclk_q, jclk_d;
    logic          load_q, load_d;
    logic          sel_q, sel_d;

    logic          tick;
    logic          tick_run;
    logic [N-1:0]  word_n;

    // Chain bits are active-low; work with the pressed=1 view.
    assign word_n   = ~shreg_q;
    assign tick_run = (state_q == LOAD) || (state_q == SHIFT);

    joy_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (tick_run),
        .tick  (tick)
    );

    assign chain.JOY_CLK  = jclk_q;
    assign chain.JOY_LOAD = load_q;
    assign chain.JOY_SEL  = sel_q;

    assign joy1   = joy1_q;
    assign joy2   = joy2_q;
    assign raw_hi = raw_hi_q;
    assign raw_lo = raw_lo_q;
    assign valid  = (state_q == DONE);

    // Scan sequencer: settle, load, shift per phase, then publish.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        half_d   = half_q;
        bit_d    = bit_q;
        timer_d  = timer_q;
        shreg_d  = shreg_q;
        cap_d    = cap_q;
        raw_hi_d = raw_hi_q;
        raw_lo_d = raw_lo_q;
        joy1_d   = joy1_q;
        joy2_d   = joy2_q;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    if (timer_q == '0) begin
                        state_d = SETTLE;
                        phase_d = 1'b0;
                        timer_d = SETTLE_RELOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (tick && !half_q) begin
                    shreg_d = {shreg_q[N-2:0], chain.JOY_DATA};
                    half_d  = 1'b1;
                end else if (tick) begin
                    half_d = 1'b0;
                    if (bit_q != LAST_BIT) begin
                        bit_d = bit_q + BW'(1);
                    end else begin
                        bit_d = '0;
                        if (!phase_q) begin
                            state_d = SETTLE;
                            phase_d = 1'b1;
                            timer_d = SETTLE_RELOAD;
                            cap_d   = word_n;
                        end else begin
                            state_d  = DONE;
                            raw_hi_d = cap_q;
                            raw_lo_d = word_n;
                            joy1_d   = md_decode(cap_q[N-1 -: 8],
                                                 word_n[N-1 -: 8]);
                            joy2_d   = md_decode(cap_q[7:0],
                                                 word_n[7:0]);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                timer_d = SCAN_RELOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Chain pins follow the next state so they leave a flop clean.
    always_comb begin
        load_d = (state_d != LOAD);
        jclk_d = (state_d == SHIFT) && half_d;
        sel_d  = 1'b1;
        if (state_d inside {SETTLE, LOAD, SHIFT}) begin
            sel_d = ~phase_d;
        end
    end

    // State, datapath and pin registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            half_q   <= 1'b0;
            bit_q    <= '0;
            timer_q  <= SCAN_RELOAD;
            shreg_q  <= '0;
            cap_q    <= '0;
            raw_hi_q <= '0;
            raw_lo_q <= '0;
            joy1_q   <= '0;
            joy2_q   <= '0;
            jclk_q   <= 1'b0;
            load_q   <= 1'b1;
            sel_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            timer_q  <= timer_d;
            shreg_q  <= shreg_d;
            cap_q    <= cap_d;
            raw_hi_q <= raw_hi_d;
            raw_lo_q <= raw_lo_d;
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
            jclk_q   <= jclk_d;
            load_q   <= load_d;
            sel_q    <= sel_d;
        end
    end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// tb_joy_serial_scanner: drives a behavioural 74HC165 chain and
// checks decoded outputs, scan timing and reset behaviour.
module tb_joy_serial_scanner;

    localparam int CD     = 4;
    localparam int NB     = 16;
    localparam int SS     = 8;
    localparam int SI     = 200;
    localparam int LAT    = 2 * (SS + CD + 2 * CD * NB) + 1;
    localparam int BUDGET = SI + LAT + 50;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [7:0]  j1;
        logic [7:0]  j2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_en = 1'b0;
    logic [7:0]  joy1;
    logic [7:0]  joy2;
    logic [15:0] raw_hi;
    logic [15:0] raw_lo;
    logic        valid;

    logic [15:0] press_hi = '0;
    logic [15:0] press_lo = '0;
    logic [15:0] sr = '1;
    logic        jclk_prev = 1'b0;
    int          rise_hi = 0;
    int          rise_lo = 0;

    int checks = 0;
    int errors = 0;

    joy_serial_scanner_if chain();

    joy_serial_scanner #(
        .CLK_DIV       (CD),
        .CHAIN_BITS    (NB),
        .SEL_SETTLE    (SS),
        .SCAN_INTERVAL (SI)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scan_en (scan_en),
        .chain   (chain),
        .joy1    (joy1),
        .joy2    (joy2),
        .raw_hi  (raw_hi),
        .raw_lo  (raw_lo),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    // Chain model: parallel load while LOAD low, shift on CLK rise.
    assign chain.JOY_DATA = sr[15];
    always @(posedge clk) begin
        jclk_prev <= chain.JOY_CLK;
        if (!chain.JOY_LOAD) begin
            sr <= ~(chain.JOY_SEL ? press_hi : press_lo);
        end else if (chain.JOY_CLK && !jclk_prev) begin
            sr <= {sr[14:0], 1'b1};
            if (chain.JOY_SEL) rise_hi <= rise_hi + 1;
            else rise_lo <= rise_lo + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; that cycle is numbered start.
    task automatic wait_valid(input int start, output int cyc,
                              output bit ok);
        ok  = 1'b0;
        cyc = start;
        while (cyc <= BUDGET + start) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_shift(input logic sel, input int nrise,
                              output bit ok);
        int n;
        int base;
        n = 0;
        while (n < BUDGET &&
               !(chain.JOY_LOAD === 1'b0 && chain.JOY_SEL === sel)) begin
            @(negedge clk);
            n++;
        end
        base = sel ? rise_hi : rise_lo;
        while (n < BUDGET && ((sel ? rise_hi : rise_lo) - base) < nrise) begin
            @(negedge clk);
            n++;
        end
        ok = (n < BUDGET);
    endtask

    initial begin
        vec_t vecs[7];
        int   cyc;
        bit   ok;
        int   bh;
        int   bl;
        int   nv;
        int   nload;
        int   n;
        bit   stay0;

        vecs[0] = '{16'h0100, 16'h1100, 8'h41, 8'h00};
        vecs[1] = '{16'h0008, 16'h0028, 8'h00, 8'h88};
        vecs[2] = '{16'h3F3F, 16'h3F3F, 8'hFF, 8'hFF};
        vecs[3] = '{16'hC0C0, 16'hC0C0, 8'h00, 8'h00};
        vecs[4] = '{16'h1020, 16'h0000, 8'h10, 8'h20};
        vecs[5] = '{16'h0000, 16'h2F10, 8'h80, 8'h40};
        vecs[6] = '{16'h0506, 16'h0000, 8'h05, 8'h06};

        #1 reset = 1'b1;
        #1;
        chk("rst_load", chain.JOY_LOAD, 1);
        chk("rst_clk", chain.JOY_CLK, 0);
        chk("rst_sel", chain.JOY_SEL, 1);
        chk("rst_joy", {joy1, joy2}, 0);
        chk("rst_raw", {raw_hi, raw_lo}, 0);
        chk("rst_valid", valid, 0);

        repeat (3) @(negedge clk);
        scan_en = 1'b1;
        reset   = 1'b0;
        wait_valid(1, cyc, ok);
        chk("first_valid_seen", ok, 1);
        chk("first_valid_cycle", cyc, SI + LAT);
        chk("idle_joy", {joy1, joy2}, 0);
        chk("idle_raw", {raw_hi, raw_lo}, 0);
        @(negedge clk);
        chk("first_pulse_width", valid, 0);

        for (int i = 0; i < 7; i++) begin
            press_hi = vecs[i].hi;
            press_lo = vecs[i].lo;
            bh = rise_hi;
            bl = rise_lo;
            wait_valid(2, cyc, ok);
            chk($sformatf("v%0d_seen", i), ok, 1);
            chk($sformatf("v%0d_period", i), cyc, SI + LAT + 1);
            chk($sformatf("v%0d_joy1", i), joy1, vecs[i].j1);
            chk($sformatf("v%0d_joy2", i), joy2, vecs[i].j2);
            chk($sformatf("v%0d_raw_hi", i), raw_hi, vecs[i].hi);
            chk($sformatf("v%0d_raw_lo", i), raw_lo, vecs[i].lo);
            chk($sformatf("v%0d_rises_hi", i), rise_hi - bh, NB);
            chk($sformatf("v%0d_rises_lo", i), rise_lo - bl, NB);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), valid, 0);
        end

        // scan_en dropped during phase-0 shift
        press_hi = 16'h0001;
        press_lo = 16'h0000;
        wait_shift(1'b1, 3, ok);
        chk("drop_reach_shift", ok, 1);
        scan_en = 1'b0;
        nv    = 0;
        nload = 0;
        for (int c = 0; c < LAT + 10 * SI; c++) begin
            @(negedge clk);
            if (valid) nv++;
            if (nv > 0 && !chain.JOY_LOAD) nload++;
        end
        chk("drop_valid_count", nv, 1);
        chk("drop_no_load", nload, 0);
        chk("drop_joy", {joy1, joy2}, 16'h0001);
        scan_en = 1'b1;
        wait_valid(1, cyc, ok);
        chk("reenable_seen", ok, 1);
        chk("reenable_cycle", cyc, SI + LAT);
        @(negedge clk);

        // reset during phase-1 shift, with JOY_CLK high
        press_hi = 16'h0300;
        press_lo = 16'h3000;
        wait_shift(1'b0, 5, ok);
        n = 0;
        while (n < 4 * CD && chain.JOY_CLK !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("mid_clk_high", chain.JOY_CLK, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_load", chain.JOY_LOAD, 1);
        chk("mid_rst_clk", chain.JOY_CLK, 0);
        chk("mid_rst_sel", chain.JOY_SEL, 1);
        chk("mid_rst_joy", {joy1, joy2}, 0);
        chk("mid_rst_raw", {raw_hi, raw_lo}, 0);
        chk("mid_rst_valid", valid, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 1;
        ok    = 1'b0;
        stay0 = 1'b1;
        while (cyc <= BUDGET) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            if ({joy1, joy2, raw_hi, raw_lo} != '0) stay0 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("post_rst_seen", ok, 1);
        chk("post_rst_held_zero", stay0, 1);
        chk("post_rst_cycle", cyc, SI + LAT);
        chk("post_rst_joy1", joy1, 8'hC3);
        chk("post_rst_joy2", joy2, 8'h00);
        chk("post_rst_raw", {raw_hi, raw_lo}, 32'h0300_3000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
